rom_frame_streamer: RTL and testbench
=====================================

Name: rom_frame_streamer

Overview:
- Reads a stored image out of a single-port ROM (e.g. blk_mem_gen_0-class IP, no clock enable) in raster order and presents it as a valid/ready pixel stream with SOF/EOL/EOF markers.
- Sits between the picture ROM and the filter/HDMI timing path.
- Generalises the fixed 16-bit-address/24-bit-data ROM access to parametrised geometry, base address and ROM read latency.
- Absorbs downstream back-pressure despite the ROM having no read stall.

Parameters:
- ADDR_WIDTH, 16, ROM address width.
- DATA_WIDTH, 24, pixel/ROM word width.
- IMG_W, 256, pixels per line (>=2).
- IMG_H, 256, lines per frame (>=1).
- BASE_ADDR, 0, ROM address of pixel (0,0).
- RD_LATENCY, 1, ROM addr-to-data cycles: 1 = no output reg, 2 = output reg.
- LOOP_EN, 0, 1 = restart the next frame automatically with no gap.

Ports:
- clk  in  1  Single clock.
- rst  in  1  Synchronous, active-high reset.
- start  in  1  One-cycle frame request; ignored while busy.
- busy  out  1  High from the cycle after an accepted start until done.
- done  out  1  One-cycle pulse after the last pixel handshakes.
- rom_addr  out  ADDR_WIDTH  Address to the ROM.
- rom_rd_data  in  DATA_WIDTH  ROM read data, valid RD_LATENCY cycles after its address.
- m_valid  out  1  Stream valid.
- m_ready  in  1  Stream ready.
- m_data  out  DATA_WIDTH  Pixel.
- m_sof  out  1  Qualifies pixel (0,0).
- m_eol  out  1  Qualifies x = IMG_W-1.
- m_eof  out  1  Qualifies the last pixel of the frame.

Behaviour:
- Reset (synchronous, active-high, rst) values: busy=0, done=0, m_valid=0, m_sof/m_eol/m_eof=0, m_data=0, rom_addr=BASE_ADDR, FSM=IDLE, x/y counters=0, FIFO empty, in-flight tags cleared.
- Reset mid-frame: aborts the frame. ROM data still in flight is discarded by tag invalidation and is never emitted.
- FSM:
  - IDLE: start=1 -> ISSUE, counters 0.
  - ISSUE: issue one read per cycle while credit is available. The cycle the last address (x=IMG_W-1, y=IMG_H-1) issues -> DRAIN.
  - DRAIN: when FIFO empty, no tags in flight and the final handshake is done -> pulse done. Go to IDLE, or to ISSUE if LOOP_EN=1 (busy stays 1, done still pulses each frame).
- Issue rule:
  - Issue when fifo_count + inflight < FIFO_DEPTH, with FIFO_DEPTH = RD_LATENCY+2.
  - rom_addr = BASE_ADDR + y*IMG_W + x, built from an incrementing address register, not a multiplier.
  - x wraps at IMG_W-1 and increments y.
- Tag pipeline:
  - RD_LATENCY-deep shift register of {valid, sof, eol, eof} travels with each address.
  - When the tag exits valid, rom_rd_data plus flags are written into the FIFO. A write is guaranteed non-full by the credit rule.
- Output:
  - The FIFO head drives m_* registers in show-ahead fashion.
  - A pop happens on m_valid & m_ready.
  - Data and flags hold stable while m_valid=1 and m_ready=0.
- Latency: start at cycle 0 -> first address cycle 1 -> first m_valid at cycle 1+RD_LATENCY+1.
- Throughput: 1 pixel/clk with m_ready held high, including across lines and across frames when LOOP_EN=1.
- Simultaneous FIFO push and pop with count=FIFO_DEPTH-1 or count=0 must be handled. No lost or duplicated pixel is allowed.
- start asserted together with rst: rst wins.
- start during busy: ignored, not queued.
- IMG_W=... with IMG_H=1: sof and eof flag the same frame, and eol is set on every line end, including the final pixel.
- Elaboration check: BASE_ADDR + IMG_W*IMG_H <= 2**ADDR_WIDTH, and RD_LATENCY is in {1,2}. Otherwise a fatal error.

Decomposition:
- Package rom_stream_pkg: FSM state enum (IDLE, ISSUE, DRAIN), flag struct {sof, eol, eof}, and a clog2 helper function.
- Sub-module rom_stream_fifo: parametrised width/depth synchronous show-ahead FIFO with count output, sync reset.

Test Plan:
- IMG_W=4, IMG_H=2, BASE_ADDR=16, RD_LATENCY=1, ROM model data=addr, m_ready=1:
  - m_data = 16..23 on consecutive cycles.
  - sof on 16, eol on 19 and 23, eof on 23.
  - done pulses once; busy falls the same cycle.
- Same setup, RD_LATENCY=2, m_ready toggling randomly 50%: exactly 8 pixels 16..23 in order, no gaps in value, no duplicates, and flags unchanged while stalled.
- m_ready=0 for 20 cycles after start: rom_addr stops after 4 issues (FIFO_DEPTH=4 at RD_LATENCY=2). On release, the stream resumes with the correct sequence.
- LOOP_EN=1, m_ready=1: second frame sof is on the cycle immediately after the first eof, done pulses once per frame, and busy stays 1.
- rst asserted at pixel 5 with reads in flight:
  - Next cycle: m_valid=0, busy=0, rom_addr=BASE_ADDR.
  - A new start yields the full frame from pixel 16 with no stale data.
- start pulsed while busy: frame count unaffected (one done per accepted start).

Source files
------------

// File: rtl/rom_stream_pkg.sv
// Shared types and helpers for the ROM frame streamer: FSM states, per-pixel
// stream flags and a constant-safe clog2.
package rom_stream_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic sof;
        logic eol;
        logic eof;
    } flags_t;

    localparam int FLAGS_W = $bits(flags_t);

    // Never returns less than 1 so degenerate sizes still give a legal vector.
    function automatic int clog2(input int value);
        int r;
        r = 1;
        while ((1 << r) < value) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/rom_stream_fifo.sv
// Small synchronous show-ahead FIFO with occupancy count; dout always shows the
// head entry, so a pop simply advances to the next one.
module rom_stream_fifo
    import rom_stream_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CW    = clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count
);

    localparam int            PW       = clog2(DEPTH);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [PW-1:0]               wr_ptr;
    logic [PW-1:0]               rd_ptr;
    logic                        do_push;
    logic                        do_pop;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop)
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rom_frame_streamer.sv
// Streams a stored image out of a stall-less single-port ROM in raster order as
// a valid/ready pixel stream; a credit-limited FIFO absorbs back-pressure.
module rom_frame_streamer
    import rom_stream_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 24,
    parameter int IMG_W      = 256,
    parameter int IMG_H      = 256,
    parameter int BASE_ADDR  = 0,
    parameter int RD_LATENCY = 1,
    parameter int LOOP_EN    = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_rd_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_sof,
    output logic                  m_eol,
    output logic                  m_eof
);

    localparam int FIFO_DEPTH = RD_LATENCY + 2;
    localparam int CW         = clog2(FIFO_DEPTH + 1);
    localparam int XW         = clog2(IMG_W);
    localparam int YW         = clog2(IMG_H);
    localparam int FW         = DATA_WIDTH + FLAGS_W;

    localparam logic [ADDR_WIDTH-1:0] BASE   = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [XW-1:0]         X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0]         Y_LAST = YW'(IMG_H - 1);

    if ((RD_LATENCY < 1) || (RD_LATENCY > 2) || (IMG_W < 2) || (IMG_H < 1) ||
        (longint'(BASE_ADDR) + longint'(IMG_W) * longint'(IMG_H) >
         (longint'(1) << ADDR_WIDTH))) begin : g_bad_params
        $fatal(1, "rom_frame_streamer: illegal geometry or RD_LATENCY");
    end

    state_t                  state;
    state_t                  state_nxt;
    logic [XW-1:0]           x;
    logic [YW-1:0]           y;
    logic [RD_LATENCY-1:0]   tag_vld;
    flags_t [RD_LATENCY-1:0] tag_flags;
    flags_t                  cur_flags;
    flags_t                  head_flags;
    logic [CW-1:0]           inflight;
    logic [CW-1:0]           fifo_count;
    logic [FW-1:0]           fifo_dout;
    logic                    credit;
    logic                    issue;
    logic                    pop;
    logic                    start_ok;

    assign cur_flags.sof = (x == '0) && (y == '0);
    assign cur_flags.eol = (x == X_LAST);
    assign cur_flags.eof = (x == X_LAST) && (y == Y_LAST);

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++)
            inflight = inflight + CW'(tag_vld[i]);
    end

    // Every read in the ROM pipe already owns a FIFO slot, so the push side
    // never has to stall something that cannot stall.
    assign credit   = (int'(fifo_count) + int'(inflight)) < FIFO_DEPTH;
    assign issue    = (state == ISSUE) && credit;
    assign start_ok = (state == IDLE) && start;
    assign busy     = (state != IDLE);

    assign head_flags = flags_t'(fifo_dout[FW-1 -: FLAGS_W]);
    assign m_valid    = (fifo_count != '0);
    assign pop        = m_valid && m_ready;
    assign m_data     = m_valid ? fifo_dout[DATA_WIDTH-1:0] : '0;
    assign m_sof      = m_valid && head_flags.sof;
    assign m_eol      = m_valid && head_flags.eol;
    assign m_eof      = m_valid && head_flags.eof;

    // In loop mode the last issue wraps straight into the next frame, which
    // keeps the stream gap-free across frame boundaries.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ISSUE;
            ISSUE:   if (issue && cur_flags.eof && (LOOP_EN == 0)) state_nxt = DRAIN;
            DRAIN:   if (pop && head_flags.eof) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            x         <= '0;
            y         <= '0;
            rom_addr  <= BASE;
            tag_vld   <= '0;
            tag_flags <= '0;
            done      <= 1'b0;
        end else begin
            state        <= state_nxt;
            done         <= pop && head_flags.eof;
            tag_vld[0]   <= issue;
            tag_flags[0] <= cur_flags;
            for (int i = 1; i < RD_LATENCY; i++) begin
                tag_vld[i]   <= tag_vld[i-1];
                tag_flags[i] <= tag_flags[i-1];
            end
            if (start_ok) begin
                x        <= '0;
                y        <= '0;
                rom_addr <= BASE;
            end else if (issue) begin
                if (cur_flags.eof) begin
                    x        <= '0;
                    y        <= '0;
                    rom_addr <= BASE;
                end else begin
                    rom_addr <= rom_addr + 1'b1;
                    if (cur_flags.eol) begin
                        x <= '0;
                        y <= y + 1'b1;
                    end else begin
                        x <= x + 1'b1;
                    end
                end
            end
        end
    end

    rom_stream_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tag_vld[RD_LATENCY-1]),
        .din   ({tag_flags[RD_LATENCY-1], rom_rd_data}),
        .pop   (pop),
        .dout  (fifo_dout),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_rom_frame_streamer.sv
// Directed bench: three streamer instances (latency 1, latency 2, loop mode) on
// a 4x2 image at base 16, each fed by a ROM model whose data equals its address.
module tb_rom_frame_streamer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst      [3];
    logic        start    [3];
    logic        m_ready  [3];
    logic        busy     [3];
    logic        done     [3];
    logic        m_valid  [3];
    logic        m_sof    [3];
    logic        m_eol    [3];
    logic        m_eof    [3];
    logic [15:0] rom_addr [3];
    logic [23:0] rd_data  [3];
    logic [23:0] m_data   [3];
    logic [23:0] rd_q1;

    int checks = 0;
    int errors = 0;

    always @(posedge clk) begin
        rd_data[0] <= {8'h00, rom_addr[0]};
        rd_q1      <= {8'h00, rom_addr[1]};
        rd_data[1] <= rd_q1;
        rd_data[2] <= {8'h00, rom_addr[2]};
    end

    rom_frame_streamer #(.IMG_W(4), .IMG_H(2), .BASE_ADDR(16), .RD_LATENCY(1), .LOOP_EN(0)) dut_a (
        .clk(clk), .rst(rst[0]), .start(start[0]), .busy(busy[0]), .done(done[0]),
        .rom_addr(rom_addr[0]), .rom_rd_data(rd_data[0]), .m_valid(m_valid[0]),
        .m_ready(m_ready[0]), .m_data(m_data[0]), .m_sof(m_sof[0]), .m_eol(m_eol[0]),
        .m_eof(m_eof[0]));

    rom_frame_streamer #(.IMG_W(4), .IMG_H(2), .BASE_ADDR(16), .RD_LATENCY(2), .LOOP_EN(0)) dut_b (
        .clk(clk), .rst(rst[1]), .start(start[1]), .busy(busy[1]), .done(done[1]),
        .rom_addr(rom_addr[1]), .rom_rd_data(rd_data[1]), .m_valid(m_valid[1]),
        .m_ready(m_ready[1]), .m_data(m_data[1]), .m_sof(m_sof[1]), .m_eol(m_eol[1]),
        .m_eof(m_eof[1]));

    rom_frame_streamer #(.IMG_W(4), .IMG_H(2), .BASE_ADDR(16), .RD_LATENCY(1), .LOOP_EN(1)) dut_c (
        .clk(clk), .rst(rst[2]), .start(start[2]), .busy(busy[2]), .done(done[2]),
        .rom_addr(rom_addr[2]), .rom_rd_data(rd_data[2]), .m_valid(m_valid[2]),
        .m_ready(m_ready[2]), .m_data(m_data[2]), .m_sof(m_sof[2]), .m_eol(m_eol[2]),
        .m_eof(m_eof[2]));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] exp_flags(input int k);
        return {k == 0, (k % 4) == 3, k == 7};
    endfunction

    // Starts a frame on instance d and scoreboards every handshake. Optional
    // random ready, an initial stall window, and a second start while busy.
    task automatic run_frame(input int d, input bit rnd, input int stall,
                             input int restart_at, input string tag);
        int          k;
        int          dones;
        bit          was_stalled;
        logic [26:0] prev;
        k = 0;
        dones = 0;
        was_stalled = 1'b0;
        prev = '0;
        start[d] = 1'b1;
        m_ready[d] = (stall == 0);
        tick();
        for (int cyc = 1; cyc < 300 && dones == 0; cyc++) begin
            start[d] = (cyc == restart_at);
            if (cyc < stall)        m_ready[d] = 1'b0;
            else if (rnd)           m_ready[d] = ($urandom_range(0, 1) != 0);
            else                    m_ready[d] = 1'b1;
            if (stall > 0 && cyc == stall) begin
                check({tag, " stall addr"}, 32'(rom_addr[d]), 32'd20);
                check({tag, " stall head"}, 32'(m_data[d]), 32'd16);
            end
            if (was_stalled) begin
                check({tag, " hold valid"}, 32'(m_valid[d]), 32'd1);
                check({tag, " hold data"},
                      32'({m_data[d], m_sof[d], m_eol[d], m_eof[d]}), 32'(prev));
            end
            if (m_valid[d] && m_ready[d]) begin
                check({tag, " data"}, 32'(m_data[d]), 32'(16 + k));
                check({tag, " flags"}, 32'({m_sof[d], m_eol[d], m_eof[d]}), 32'(exp_flags(k)));
                k++;
            end
            was_stalled = m_valid[d] && !m_ready[d];
            prev = {m_data[d], m_sof[d], m_eol[d], m_eof[d]};
            if (done[d]) begin
                dones++;
                check({tag, " busy at done"}, 32'(busy[d]), 32'd0);
            end
            tick();
        end
        start[d] = 1'b0;
        check({tag, " pixel count"}, 32'(k), 32'd8);
        check({tag, " done count"}, 32'(dones), 32'd1);
    endtask

    initial begin
        bit v;
        int k;
        for (int d = 0; d < 3; d++) begin
            rst[d] = 1'b1;
            start[d] = 1'b0;
            m_ready[d] = 1'b0;
        end
        tick();
        tick();
        for (int d = 0; d < 3; d++) begin
            check("reset busy", 32'(busy[d]), 32'd0);
            check("reset done", 32'(done[d]), 32'd0);
            check("reset valid", 32'(m_valid[d]), 32'd0);
            check("reset data", 32'(m_data[d]), 32'd0);
            check("reset addr", 32'(rom_addr[d]), 32'd16);
            rst[d] = 1'b0;
        end
        tick();

        // Latency 1, ready high: pixels on cycles 3..10, done on 11.
        start[0] = 1'b1;
        m_ready[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            v = (c >= 3) && (c <= 10);
            k = c - 3;
            if (c == 1) check("t1 first addr", 32'(rom_addr[0]), 32'd16);
            check("t1 valid", 32'(m_valid[0]), 32'(v));
            if (v) begin
                check("t1 data", 32'(m_data[0]), 32'(16 + k));
                check("t1 flags", 32'({m_sof[0], m_eol[0], m_eof[0]}), 32'(exp_flags(k)));
            end
            check("t1 done", 32'(done[0]), 32'(c == 11));
            check("t1 busy", 32'(busy[0]), 32'(c <= 10));
            tick();
        end

        // Latency 2 under random back-pressure, then a 20-cycle initial stall.
        run_frame(1, 1'b1, 0, 0, "t2 random");
        tick();
        run_frame(1, 1'b0, 20, 0, "t3 stall");
        tick();

        // Loop mode: frames back to back, done once per frame, busy stays high.
        start[2] = 1'b1;
        m_ready[2] = 1'b1;
        tick();
        start[2] = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            v = (c >= 3);
            k = (c - 3) % 8;
            check("t4 valid", 32'(m_valid[2]), 32'(v));
            if (v) begin
                check("t4 data", 32'(m_data[2]), 32'(16 + k));
                check("t4 flags", 32'({m_sof[2], m_eol[2], m_eof[2]}), 32'(exp_flags(k)));
            end
            check("t4 done", 32'(done[2]), 32'((c == 11) || (c == 19)));
            check("t4 busy", 32'(busy[2]), 32'd1);
            tick();
        end
        rst[2] = 1'b1;
        tick();
        rst[2] = 1'b0;
        check("t4 stop busy", 32'(busy[2]), 32'd0);
        check("t4 stop valid", 32'(m_valid[2]), 32'd0);

        // Reset while pixel 5 (value 21) is at the head with reads in flight.
        start[0] = 1'b1;
        m_ready[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        for (int c = 1; c < 8; c++) tick();
        check("t5 pre-reset data", 32'(m_data[0]), 32'd21);
        rst[0] = 1'b1;
        tick();
        rst[0] = 1'b0;
        check("t5 valid", 32'(m_valid[0]), 32'd0);
        check("t5 busy", 32'(busy[0]), 32'd0);
        check("t5 addr", 32'(rom_addr[0]), 32'd16);
        tick();
        check("t5 no stale", 32'(m_valid[0]), 32'd0);
        run_frame(0, 1'b0, 0, 0, "t5 restart");
        tick();

        // Start together with reset is dropped.
        rst[0] = 1'b1;
        start[0] = 1'b1;
        tick();
        rst[0] = 1'b0;
        start[0] = 1'b0;
        tick();
        check("t6 rst wins busy", 32'(busy[0]), 32'd0);

        // A start while busy must not queue another frame.
        run_frame(0, 1'b0, 0, 4, "t7 restart");
        for (int c = 0; c < 6; c++) tick();
        check("t7 idle after", 32'(busy[0]), 32'd0);
        check("t7 no extra pixel", 32'(m_valid[0]), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
